// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - registered ALU result stage: HI/LO owner, write-back select, result FIFO, sticky overflow
module alu_result_stage #(
   parameter int DEPTH = 2,
   parameter int W     = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [4:0]   FS,
   input  logic [1:0]   D_sel,
   input  logic [W-1:0] Y_hi,
   input  logic [W-1:0] Y_lo,
   input  logic         C,
   input  logic         V,
   input  logic         N,
   input  logic         Z,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] ALU_Out,
   output logic [3:0]   flags_out,
   output logic [W-1:0] HI,
   output logic [W-1:0] LO,
   output logic         ov_sticky,
   input  logic         ov_clr
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = W + 4;

   localparam logic [4:0] FS_ADD = 5'h02;
   localparam logic [4:0] FS_SUB = 5'h04;
   localparam logic [4:0] FS_MUL = 5'h1E;
   localparam logic [4:0] FS_DIV = 5'h1F;

   // Each entry packs the write-back word above the {C,V,N,Z} flags.
   logic [EW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] rd_ptr_nxt;
   logic [CW-1:0] count;
   logic [CW-1:0] count_nxt;
   logic [EW-1:0] head_q;
   logic [EW-1:0] head_nxt;
   logic [EW-1:0] in_entry;
   logic [W-1:0]  in_word;
   logic          push;
   logic          pop;
   logic          hilo_load;
   logic          ov_set;

   // Handshake status comes only from the registered count, so out_ready
   // never reaches in_ready combinationally.
   assign in_ready  = (count != CW'(DEPTH));
   assign out_valid = (count != '0);
   assign ALU_Out   = head_q[EW-1:4];
   assign flags_out = head_q[3:0];

   // Entry formation, occupancy bookkeeping and next head selection.
   always_comb begin
      push       = in_valid && in_ready;
      pop        = out_valid && out_ready;
      hilo_load  = push && ((FS == FS_MUL) || (FS == FS_DIV));
      ov_set     = push && V && ((FS == FS_ADD) || (FS == FS_SUB));
      in_word    = Y_lo;
      case (D_sel)
         2'd1:    in_word = HI;
         2'd2:    in_word = LO;
         default: in_word = Y_lo;
      endcase
      in_entry   = {in_word, C, V, N, Z};
      count_nxt  = count;
      case ({push, pop})
         2'b10:   count_nxt = count + CW'(1);
         2'b01:   count_nxt = count - CW'(1);
         default: count_nxt = count;
      endcase
      rd_ptr_nxt = pop ? rd_ptr + AW'(1) : rd_ptr;
      // The head register tracks the oldest entry after this edge; an entry
      // written into the slot that becomes the head bypasses the array.
      // With nothing left it keeps the last popped value.
      head_nxt   = head_q;
      if (count_nxt != '0) begin
         if (push && (wr_ptr == rd_ptr_nxt)) begin
            head_nxt = in_entry;
         end else begin
            head_nxt = mem[rd_ptr_nxt];
         end
      end
   end

   // FIFO pointers, occupancy and head register.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         head_q <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         rd_ptr <= rd_ptr_nxt;
         count  <= count_nxt;
         head_q <= head_nxt;
      end
   end

   // Entry storage; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= in_entry;
      end
   end

   // Architectural HI/LO: written only by an accepted MUL or DIV.
   always_ff @(posedge clk) begin
      if (reset) begin
         HI <= '0;
         LO <= '0;
      end else if (hilo_load) begin
         HI <= Y_hi;
         LO <= Y_lo;
      end
   end

   // Sticky signed overflow; a new overflow beats a same-cycle clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         ov_sticky <= 1'b0;
      end else if (ov_set) begin
         ov_sticky <= 1'b1;
      end else if (ov_clr) begin
         ov_sticky <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_result_stage.sv
// tb/tb_alu_result_stage.sv - directed self-checking bench for alu_result_stage
module tb_alu_result_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  FS;
   logic [1:0]  D_sel;
   logic [31:0] Y_hi;
   logic [31:0] Y_lo;
   logic        C, V, N, Z;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] ALU_Out;
   logic [3:0]  flags_out;
   logic [31:0] HI;
   logic [31:0] LO;
   logic        ov_sticky;
   logic        ov_clr;

   int tests_run = 0;
   int tests_failed = 0;

   alu_result_stage #(.DEPTH(2), .W(32)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .FS(FS), .D_sel(D_sel), .Y_hi(Y_hi), .Y_lo(Y_lo),
      .C(C), .V(V), .N(N), .Z(Z),
      .out_valid(out_valid), .out_ready(out_ready),
      .ALU_Out(ALU_Out), .flags_out(flags_out),
      .HI(HI), .LO(LO), .ov_sticky(ov_sticky), .ov_clr(ov_clr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [4:0] fs, input logic [1:0] ds,
                        input logic [31:0] hi, input logic [31:0] lo, input logic vf);
      in_valid = v;
      FS       = fs;
      D_sel    = ds;
      Y_hi     = hi;
      Y_lo     = lo;
      V        = vf;
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; FS = '0; D_sel = '0; Y_hi = '0; Y_lo = '0;
      C = 1'b0; V = 1'b0; N = 1'b0; Z = 1'b0; out_ready = 1'b0; ov_clr = 1'b0;
      step(); step();
      reset = 1'b0;

      // Reset state
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_alu_out", ALU_Out, 32'd0);
      check("rst_flags", 32'(flags_out), 32'd0);
      check("rst_hi", HI, 32'd0);
      check("rst_lo", LO, 32'd0);
      check("rst_ov", 32'(ov_sticky), 32'd0);

      // 1: single ADD result through the stage
      out_ready = 1'b1;
      C = 1'b1; Z = 1'b1;
      drive(1'b1, 5'h02, 2'd0, 32'h0, 32'h5, 1'b0);
      step();
      check("t1_out_valid", 32'(out_valid), 32'd1);
      check("t1_alu_out", ALU_Out, 32'h5);
      check("t1_flags", 32'(flags_out), 32'b1001);
      C = 1'b0; Z = 1'b0;
      drive(1'b0, 5'h00, 2'd0, 32'h0, 32'h0, 1'b0);
      step();
      check("t1_empty", 32'(out_valid), 32'd0);
      check("t1_hold", ALU_Out, 32'h5);
      check("t1_in_ready", 32'(in_ready), 32'd1);

      // 2: fill to full, third push refused, ordered drain
      out_ready = 1'b0;
      drive(1'b1, 5'h00, 2'd0, 32'h0, 32'h1, 1'b0); step();
      drive(1'b1, 5'h00, 2'd0, 32'h0, 32'h2, 1'b0); step();
      check("t2_full_in_ready", 32'(in_ready), 32'd0);
      drive(1'b1, 5'h00, 2'd0, 32'h0, 32'h3, 1'b0); step();
      drive(1'b0, 5'h00, 2'd0, 32'h0, 32'h0, 1'b0);
      check("t2_head1", ALU_Out, 32'h1);
      out_ready = 1'b1;
      step();
      check("t2_head2", ALU_Out, 32'h2);
      check("t2_in_ready_back", 32'(in_ready), 32'd1);
      step();
      check("t2_drained", 32'(out_valid), 32'd0);
      check("t2_hold", ALU_Out, 32'h2);

      // 3: MUL loads HI/LO, MFHI/MFLO read them back
      drive(1'b1, 5'h1E, 2'd0, 32'hDEAD, 32'hBEEF, 1'b0); step();
      check("t3_hi", HI, 32'hDEAD);
      check("t3_lo", LO, 32'hBEEF);
      check("t3_e0", ALU_Out, 32'hBEEF);
      drive(1'b1, 5'h00, 2'd1, 32'h1111, 32'h1234, 1'b0); step();
      check("t3_e1", ALU_Out, 32'hDEAD);
      check("t3_hi_kept", HI, 32'hDEAD);
      drive(1'b1, 5'h00, 2'd2, 32'h2222, 32'h5678, 1'b0); step();
      check("t3_e2", ALU_Out, 32'hBEEF);
      check("t3_lo_kept", LO, 32'hBEEF);
      drive(1'b0, 5'h1F, 2'd0, 32'h9999, 32'h8888, 1'b0); step();
      check("t3_no_push_no_load", HI, 32'hDEAD);

      // 4: sticky overflow
      drive(1'b1, 5'h02, 2'd0, 32'h0, 32'h0, 1'b1); step();
      check("t4_add_set", 32'(ov_sticky), 32'd1);
      check("t4_flags_v", 32'(flags_out), 32'b0100);
      drive(1'b1, 5'h03, 2'd0, 32'h0, 32'h0, 1'b1); step();
      check("t4_addu_stays", 32'(ov_sticky), 32'd1);
      ov_clr = 1'b1;
      drive(1'b1, 5'h02, 2'd0, 32'h0, 32'h0, 1'b1); step();
      check("t4_set_wins", 32'(ov_sticky), 32'd1);
      drive(1'b0, 5'h00, 2'd0, 32'h0, 32'h0, 1'b0); step();
      check("t4_clear", 32'(ov_sticky), 32'd0);
      ov_clr = 1'b0;
      drive(1'b1, 5'h05, 2'd0, 32'h0, 32'h0, 1'b1); step();
      check("t4_subu_no_set", 32'(ov_sticky), 32'd0);
      drive(1'b1, 5'h04, 2'd0, 32'h0, 32'h0, 1'b1); step();
      check("t4_sub_set", 32'(ov_sticky), 32'd1);
      drive(1'b0, 5'h00, 2'd0, 32'h0, 32'h0, 1'b0); ov_clr = 1'b1; step();
      ov_clr = 1'b0;

      // 5: reset with a full FIFO discards everything
      out_ready = 1'b0;
      drive(1'b1, 5'h1E, 2'd0, 32'h11, 32'hA, 1'b0); step();
      drive(1'b1, 5'h00, 2'd0, 32'h0, 32'hB, 1'b0); step();
      drive(1'b0, 5'h00, 2'd0, 32'h0, 32'h0, 1'b0);
      check("t5_full", 32'(in_ready), 32'd0);
      reset = 1'b1; step(); reset = 1'b0;
      check("t5_out_valid", 32'(out_valid), 32'd0);
      check("t5_in_ready", 32'(in_ready), 32'd1);
      check("t5_hi", HI, 32'd0);
      check("t5_lo", LO, 32'd0);
      out_ready = 1'b1;
      drive(1'b1, 5'h00, 2'd0, 32'h0, 32'h7, 1'b0); step();
      check("t5_first", ALU_Out, 32'h7);
      check("t5_valid", 32'(out_valid), 32'd1);
      drive(1'b0, 5'h00, 2'd0, 32'h0, 32'h0, 1'b0); step();
      check("t5_drained", 32'(out_valid), 32'd0);

      // 6: sustained push/pop, pointers wrap
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 5'h00, 2'd0, 32'h0, 32'(i), 1'b0);
         step();
         check($sformatf("t6_valid_%0d", i), 32'(out_valid), 32'd1);
         check($sformatf("t6_data_%0d", i), ALU_Out, 32'(i));
         check($sformatf("t6_ready_%0d", i), 32'(in_ready), 32'd1);
      end
      drive(1'b0, 5'h00, 2'd0, 32'h0, 32'h0, 1'b0); step();
      check("t6_empty", 32'(out_valid), 32'd0);
      check("t6_hold", ALU_Out, 32'h7);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
